ipsl_pcie_pipe_reg: RTL and testbench
=====================================

IPSL_PCIE_PIPE_REG -- requirements
Module: ipsl_pcie_pipe_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width in bits; legal range 1..512.
REQ-002 Parameter STAGES, default 2: number of cascaded register stages; legal range 1..8.
REQ-003 Parameter MODE, default 1: 0 = forward register (combinational ready path); 1 = full skid buffer (registered ready path).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all buffered data.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 in_ready  output  1  block accepts the upstream word this cycle.
REQ-010 out_valid  output  1  downstream word present.
REQ-011 out_data  output  DATA_WIDTH  downstream payload.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.
REQ-013 occupancy  output  $clog2(2*STAGES+1)  number of words currently held, all stages.

Function
REQ-014 A transfer SHALL occur on a port exactly when valid and ready are both high at a rising clk edge.
REQ-015 Each stage SHALL hold a main register (valid, data); in MODE 1 each stage SHALL also hold one skid register (valid, data).
REQ-016 Words SHALL leave in arrival order, with no loss and no duplication.
REQ-017 Latency from in_valid/in_data to out_valid/out_data SHALL be exactly STAGES cycles when the pipeline is empty and out_ready is held high.
REQ-018 With out_ready held high, throughput SHALL be one word per cycle in both modes.
REQ-019 out_valid and out_data SHALL be driven directly from the last stage's main register, with no combinational path from inputs.
REQ-020 MODE 0, per stage: stage_in_ready = next_ready OR NOT main_valid.
REQ-021 MODE 0, per stage: main captures input when stage_in_ready is high.
REQ-022 MODE 1, per stage: stage_in_ready SHALL be the registered value NOT skid_valid, with no combinational dependency on out_ready.
REQ-023 MODE 1, per stage, main empty, or main draining this cycle with skid empty: an accepted input SHALL load main.
REQ-024 MODE 1, per stage, main full and not draining: an accepted input SHALL load skid.
REQ-025 MODE 1, per stage, main draining with skid full: main SHALL load from skid and skid SHALL clear, or reload from the input when the input is accepted the same cycle.
REQ-026 Main data registers SHALL hold their value when not loading; data SHALL not be cleared on pop.
REQ-027 occupancy SHALL update in the cycle after each transfer.
REQ-028 occupancy SHALL increment on input-only transfer, decrement on output-only transfer, and stay unchanged on a simultaneous input and output transfer.
REQ-029 occupancy maximum SHALL be STAGES in MODE 0 and 2*STAGES in MODE 1.
REQ-030 When full (MODE 1), in_ready SHALL be low.
REQ-031 When empty, out_valid SHALL be low and out_data SHALL hold its last value.
REQ-032 flush SHALL clear all valid bits and occupancy at the next edge, overriding any simultaneous input transfer; the word offered that cycle SHALL be dropped.
REQ-033 in_ready SHALL be high in the cycle after a flush.
REQ-034 out_valid SHALL not deassert without a completed output transfer, except on flush or rst.

Reset
REQ-035 rst high SHALL asynchronously clear all main and skid valid bits, occupancy, and out_valid.
REQ-036 Under rst, in_ready SHALL read 1 in MODE 1 and follow REQ-020 with all stages empty in MODE 0.
REQ-037 Data registers SHALL not be reset.
REQ-038 rst asserted mid-stream SHALL discard all held words.
REQ-039 After rst deasserts, operation SHALL resume on the first following edge.

Structure
REQ-040 Mode encodings (MODE_FWD=0, MODE_SKID=1) SHALL live in shared package ipsl_pcie_pkg, alongside the occupancy width function.
REQ-041 One sub-module, ipsl_pcie_pipe_stage (DATA_WIDTH, MODE), SHALL implement one stage and be instantiated STAGES times by a generate loop.
REQ-042 The top level SHALL contain only the stage chain and the occupancy counter.

Verification
REQ-043 Streaming: MODE 1, STAGES=2, out_ready=1, push 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 on consecutive cycles, first word 2 cycles after first push.
REQ-044 Backpressure fill: MODE 1, STAGES=2, out_ready=0, push continuously -> exactly 4 words accepted; in_ready low from the 5th cycle; occupancy=4.
REQ-045 Release: from the REQ-044 state, raise out_ready with no input -> 4 words out in order over 4 consecutive cycles; occupancy reaches 0.
REQ-046 Simultaneous push/pop: occupancy=2, in and out transfers in the same cycle -> occupancy stays 2 and order is preserved.
REQ-047 Flush: occupancy=3, flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, and the flushed input word never appears at the output.
REQ-048 Reset mid-stream and MODE 0: assert rst asynchronously mid-stream -> out_valid=0 immediately; then MODE 0, STAGES=3 -> in_ready equals out_ready when full, latency 3, random-backpressure scoreboard clean across 10k words.

Source files
------------

// File: rtl/ipsl_pcie_pkg.sv
// Shared definitions for the PCIe pipe register slice: mode encodings and the
// occupancy counter width helper.
package ipsl_pcie_pkg;

  localparam int unsigned MODE_FWD  = 0;  // forward register, combinational ready
  localparam int unsigned MODE_SKID = 1;  // skid buffer, registered ready

  // Width wide enough to count 0..2*stages words (skid mode holds two per stage).
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/ipsl_pcie_pipe_stage.sv
// One valid/ready register stage. MODE_FWD is a plain forward register whose
// ready is combinational from downstream; MODE_SKID adds a skid register so
// the upstream ready comes straight from a flop.
module ipsl_pcie_pipe_stage
  import ipsl_pcie_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MODE       = MODE_SKID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  logic                  r_main_valid;
  logic [DATA_WIDTH-1:0] r_main_data;

  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;

  if (MODE == MODE_SKID) begin : g_skid
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load_main;

    assign o_ready     = ~r_skid_valid;
    assign w_push      = i_valid & ~r_skid_valid;
    assign w_pop       = r_main_valid & i_ready;
    // Main takes the input directly when it is empty or draining with no skid word.
    assign w_load_main = ~r_main_valid | (w_pop & ~r_skid_valid);

    // Valid bits: main/skid occupancy with flush as a synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_load_main) begin
        r_main_valid <= w_push;
      end else if (!w_pop) begin
        if (w_push) r_skid_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b1;
        r_skid_valid <= w_push;
      end
    end

    // Data registers: no reset, hold unless loading.
    always_ff @(posedge clk) begin
      if (!flush) begin
        if (w_load_main) begin
          if (w_push) r_main_data <= i_data;
        end else if (!w_pop) begin
          if (w_push) r_skid_data <= i_data;
        end else begin
          r_main_data <= r_skid_data;
          if (w_push) r_skid_data <= i_data;
        end
      end
    end
  end else begin : g_fwd
    assign o_ready = i_ready | ~r_main_valid;

    // Valid bit: refill whenever the slot is free or being drained.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_valid <= 1'b0;
      end else if (flush) begin
        r_main_valid <= 1'b0;
      end else if (o_ready) begin
        r_main_valid <= i_valid;
      end
    end

    // Data register: no reset, capture only on an accepted word.
    always_ff @(posedge clk) begin
      if (!flush && o_ready && i_valid) r_main_data <= i_data;
    end
  end

endmodule

// File: rtl/ipsl_pcie_pipe_reg.sv
// Cascaded valid/ready pipe register: STAGES stages plus a word occupancy
// counter covering the whole chain.
module ipsl_pcie_pipe_reg
  import ipsl_pcie_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned MODE       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int unsigned OccW = occ_width(STAGES);

  // Index g is the link feeding stage g; index STAGES is the output port.
  logic [STAGES:0]       w_valid;
  logic [STAGES:0]       w_ready;
  logic [DATA_WIDTH-1:0] w_data [STAGES+1];
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [OccW-1:0]       r_occ;

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign w_ready[STAGES] = out_ready;
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign occupancy       = r_occ;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    ipsl_pcie_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE       (MODE)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .i_valid (w_valid[g]),
      .i_data  (w_data[g]),
      .o_ready (w_ready[g]),
      .o_valid (w_valid[g+1]),
      .o_data  (w_data[g+1]),
      .i_ready (w_ready[g+1])
    );
  end

  assign w_in_fire  = in_valid & w_ready[0];
  assign w_out_fire = w_valid[STAGES] & out_ready;

  // Occupancy: +1 on input-only, -1 on output-only transfer; flush empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b10:   r_occ <= r_occ + OccW'(1);
        2'b01:   r_occ <= r_occ - OccW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_pipe_reg.sv
// Bench for ipsl_pcie_pipe_reg: a skid-mode instance (STAGES=2) driven from a
// vector table plus reset/latency sequences, and a forward-mode instance
// (STAGES=3) with latency, full-ready and random-backpressure scoreboard checks.
module tb_ipsl_pcie_pipe_reg;
  import ipsl_pcie_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       a_flush, a_iv, a_ir, a_ov, a_ordy;
  logic [7:0] a_id, a_od;
  logic [2:0] a_occ;

  logic        b_flush, b_iv, b_ir, b_ov, b_ordy;
  logic [15:0] b_id, b_od;
  logic [2:0]  b_occ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ipsl_pcie_pipe_reg #(.DATA_WIDTH(8), .STAGES(2), .MODE(MODE_SKID)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (a_flush),
    .in_valid  (a_iv),
    .in_data   (a_id),
    .in_ready  (a_ir),
    .out_valid (a_ov),
    .out_data  (a_od),
    .out_ready (a_ordy),
    .occupancy (a_occ)
  );

  ipsl_pcie_pipe_reg #(.DATA_WIDTH(16), .STAGES(3), .MODE(MODE_FWD)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (b_flush),
    .in_valid  (b_iv),
    .in_data   (b_id),
    .in_ready  (b_ir),
    .out_valid (b_ov),
    .out_data  (b_od),
    .out_ready (b_ordy),
    .occupancy (b_occ)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       chk_d;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic fl, input logic e_ir, input logic e_ov,
                              input logic [7:0] e_od, input logic chk_d,
                              input logic [2:0] e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_d = chk_d; v.e_occ = e_occ;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] exp_w;
    logic [15:0] q[$];
    int          sent, recv, cyc;
    logic        prev_ov, prev_fire, in_fire, out_fire;
    logic [15:0] prev_od;

    // Streaming: 0x01..0x10 back to back, out_ready high.
    for (int i = 0; i < 19; i++) begin
      tbl.push_back(mk(i < 16, (i < 16) ? 8'(i + 1) : 8'h00, 1'b1, 1'b0, 1'b1,
                       (i >= 2) && (i <= 17), (i <= 17) ? 8'(i - 1) : 8'h10, i >= 2,
                       (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : (i <= 16) ? 3'd2 :
                       (i == 17) ? 3'd1 : 3'd0));
    end
    // Backpressure fill: out_ready low, continuous pushes.
    tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 8'h10, 1, 3'd0));
    tbl.push_back(mk(1, 8'hA2, 0, 0, 1, 0, 8'h10, 1, 3'd1));
    tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 1, 8'hA1, 1, 3'd2));
    tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 1, 8'hA1, 1, 3'd3));
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 1, 8'hA1, 1, 3'd4));
    tbl.push_back(mk(1, 8'hA6, 0, 0, 0, 1, 8'hA1, 1, 3'd4));
    // Release with no input.
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hA1, 1, 3'd4));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 8'hA2, 1, 3'd3));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, 1, 3'd2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1, 3'd1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA4, 1, 3'd0));
    // Simultaneous push/pop at occupancy 2, then build up to 3 and flush.
    tbl.push_back(mk(1, 8'hB1, 0, 0, 1, 0, 8'hA4, 1, 3'd0));
    tbl.push_back(mk(1, 8'hB2, 0, 0, 1, 0, 8'hA4, 1, 3'd1));
    tbl.push_back(mk(1, 8'hB3, 1, 0, 1, 1, 8'hB1, 1, 3'd2));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hB2, 1, 3'd2));
    tbl.push_back(mk(1, 8'hB4, 0, 0, 1, 1, 8'hB3, 1, 3'd1));
    tbl.push_back(mk(1, 8'hB5, 0, 0, 1, 1, 8'hB3, 1, 3'd2));
    tbl.push_back(mk(1, 8'hEE, 0, 1, 1, 1, 8'hB3, 1, 3'd3));
    // After flush: empty, flushed word never shows, pipe still works.
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hB3, 1, 3'd0));
    tbl.push_back(mk(1, 8'hC1, 1, 0, 1, 0, 8'hB3, 1, 3'd0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hB3, 1, 3'd1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hC1, 1, 3'd1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hC1, 1, 3'd0));

    rst = 1'b1;
    a_flush = 0; a_iv = 0; a_id = '0; a_ordy = 0;
    b_flush = 0; b_iv = 0; b_id = '0; b_ordy = 0;
    repeat (2) @(negedge clk);
    chk("a reset in_ready", a_ir, 1);
    chk("a reset out_valid", a_ov, 0);
    chk("a reset occupancy", a_occ, 0);
    chk("b reset in_ready", b_ir, 1);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      a_iv = tbl[i].iv; a_id = tbl[i].id; a_ordy = tbl[i].ordy; a_flush = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d in_ready", i), a_ir, tbl[i].e_ir);
      chk($sformatf("vec%0d out_valid", i), a_ov, tbl[i].e_ov);
      if (tbl[i].chk_d) chk($sformatf("vec%0d out_data", i), a_od, tbl[i].e_od);
      chk($sformatf("vec%0d occupancy", i), a_occ, tbl[i].e_occ);
    end

    // Asynchronous reset mid-stream on the skid instance.
    @(negedge clk); a_flush = 0; a_iv = 1; a_id = 8'hD1; a_ordy = 0;
    @(negedge clk); a_id = 8'hD2;
    @(negedge clk); a_id = 8'hD3;
    @(negedge clk); a_iv = 0;
    #1;
    chk("a pre-rst occupancy", a_occ, 3);
    chk("a pre-rst out_valid", a_ov, 1);
    #2 rst = 1'b1;
    #1;
    chk("a rst out_valid", a_ov, 0);
    chk("a rst occupancy", a_occ, 0);
    chk("a rst in_ready", a_ir, 1);
    @(negedge clk); rst = 1'b0;
    a_iv = 1; a_id = 8'h5A; a_ordy = 1;
    lat = 0;
    do begin
      @(negedge clk); a_iv = 0; #1; lat++;
    end while (!a_ov && lat < 8);
    chk("a post-rst latency", lat, 2);
    chk("a post-rst data", a_od, 8'h5A);
    @(negedge clk); #1;
    chk("a post-rst drained", a_ov, 0);

    // Forward mode: latency 3 from empty.
    @(negedge clk); b_iv = 1; b_id = 16'h1234; b_ordy = 1;
    lat = 0;
    do begin
      @(negedge clk); b_iv = 0; #1; lat++;
    end while (!b_ov && lat < 8);
    chk("b latency", lat, 3);
    chk("b latency data", b_od, 16'h1234);

    // Forward mode full: three words held, in_ready follows out_ready.
    @(negedge clk); b_ordy = 0; b_iv = 1;
    for (int i = 0; i < 5; i++) begin
      b_id = 16'h0100 + 16'(i);
      @(negedge clk);
    end
    b_iv = 0; #1;
    chk("b full occupancy", b_occ, 3);
    chk("b full in_ready lo", b_ir, 0);
    chk("b full out_data", b_od, 16'h0100);
    b_ordy = 1; #1;
    chk("b full in_ready follows", b_ir, 1);
    b_ordy = 0; #1;
    chk("b full in_ready drops", b_ir, 0);
    b_ordy = 1;
    exp_w = 16'h0100;
    for (int k = 0; k < 5; k++) begin
      if (b_ov) begin
        chk("b drain order", b_od, exp_w);
        exp_w++;
      end
      @(negedge clk); #1;
    end
    chk("b drain count", exp_w, 16'h0103);
    chk("b drain occupancy", b_occ, 0);

    // Random backpressure scoreboard over 10000 words.
    sent = 0; recv = 0; cyc = 0; prev_ov = 0; prev_fire = 0; prev_od = '0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      b_iv   = (sent < 10000) && ($urandom_range(0, 3) != 0);
      b_id   = 16'(sent) ^ 16'h5A00;
      b_ordy = $urandom_range(0, 3) != 0;
      #1;
      if (prev_ov && !prev_fire) begin
        chk("b sb valid held", b_ov, 1);
        chk("b sb data held", b_od, prev_od);
      end
      chk("b sb occupancy", b_occ, q.size());
      if (b_occ == 3'd3) chk("b sb full ready", b_ir, b_ordy);
      in_fire  = b_iv & b_ir;
      out_fire = b_ov & b_ordy;
      if (out_fire) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b sb pop: actual=unexpected word %0h required=no word", b_od);
        end else begin
          chk("b sb data", b_od, q.pop_front());
        end
        recv++;
      end
      if (in_fire) begin
        q.push_back(b_id);
        sent++;
      end
      prev_ov = b_ov; prev_fire = out_fire; prev_od = b_od;
      cyc++;
    end
    chk("b sb sent", sent, 10000);
    chk("b sb received", recv, 10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
